// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - raster timing defaults, counter width and axis phase encoding
package vga_sync_gen_pkg;

   localparam int CW        = 10;
   localparam int MAX_TOTAL = 1 << CW;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_e;

   function automatic int axis_total(input int active, input int front,
                                     input int sync, input int back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter, phase FSM and sync decode
module vga_axis_counter
   import vga_sync_gen_pkg::*;
#(
   parameter int ACTIVE   = DEF_H_ACTIVE,
   parameter int FRONT    = DEF_H_FRONT,
   parameter int SYNC     = DEF_H_SYNC,
   parameter int BACK     = DEF_H_BACK,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          advance_i,
   output logic [CW-1:0] count_o,
   output phase_e        phase_d_o,
   output logic          sync_o
);

   localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

   localparam logic [CW-1:0] LAST_C       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] FRONT_START  = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_START   = CW'(ACTIVE + FRONT);
   localparam logic [CW-1:0] BACK_START   = CW'(ACTIVE + FRONT + SYNC);

   logic [CW-1:0] count_q, count_d;
   phase_e        phase_q, phase_d;
   logic          sync_q, sync_d;
   logic          wrap;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         phase_q <= PH_ACTIVE;
         sync_q  <= ~SYNC_POL;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
         sync_q  <= sync_d;
      end
   end

   // Phase changes are keyed on the value being loaded, so phase_q always matches count_q.
   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      wrap    = 1'b0;
      if (advance_i) begin
         if (count_q == LAST_C) begin
            count_d = '0;
            wrap    = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
         unique case (phase_q)
            PH_ACTIVE: if (count_d == FRONT_START) phase_d = PH_FRONT;
            PH_FRONT:  if (count_d == SYNC_START)  phase_d = PH_SYNC;
            PH_SYNC:   if (count_d == BACK_START)  phase_d = PH_BACK;
            PH_BACK:   if (wrap)                   phase_d = PH_ACTIVE;
         endcase
      end
      sync_d = (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
   end

   assign count_o   = count_q;
   assign phase_d_o = phase_d;
   assign sync_o    = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing source: counters, syncs, display flag, line/frame pulses
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clk_en,
   output logic [CW-1:0] CounterX,
   output logic [CW-1:0] CounterY,
   output logic          hsync,
   output logic          vsync,
   output logic          inDisplayArea,
   output logic          line_start,
   output logic          frame_tick
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
      $error("vga_sync_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
   end
   if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
      $error("vga_sync_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
   end

   localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST_DISP = CW'(V_ACTIVE - 1);

   logic   h_wrap;
   phase_e h_phase_d, v_phase_d;

   assign h_wrap = clk_en && (CounterX == H_LAST);

   vga_axis_counter #(
      .ACTIVE   (H_ACTIVE),
      .FRONT    (H_FRONT),
      .SYNC     (H_SYNC),
      .BACK     (H_BACK),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .clk       (clk),
      .reset     (reset),
      .advance_i (clk_en),
      .count_o   (CounterX),
      .phase_d_o (h_phase_d),
      .sync_o    (hsync)
   );

   vga_axis_counter #(
      .ACTIVE   (V_ACTIVE),
      .FRONT    (V_FRONT),
      .SYNC     (V_SYNC),
      .BACK     (V_BACK),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .clk       (clk),
      .reset     (reset),
      .advance_i (h_wrap),
      .count_o   (CounterY),
      .phase_d_o (v_phase_d),
      .sync_o    (vsync)
   );

   logic disp_q, disp_d;
   logic line_q, line_d;
   logic frame_q, frame_d;

   // Display flag must hold while disabled so the post-reset blank pixel stays blank.
   always_comb begin
      disp_d  = disp_q;
      if (clk_en) begin
         disp_d = (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);
      end
      line_d  = h_wrap;
      frame_d = h_wrap && (CounterY == V_LAST_DISP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_q  <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         disp_q  <= disp_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   assign inDisplayArea = disp_q;
   assign line_start    = line_q;
   assign frame_tick    = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench: default 640x480 timing plus a reduced-size raster
module tb_vga_sync_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clk_en = 1'b0;

   logic [9:0] x0, y0, x1, y1;
   logic       hs0, vs0, da0, ls0, ft0;
   logic       hs1, vs1, da1, ls1, ft1;

   int n_checks = 0;
   int n_fail   = 0;

   // Timing of instance 0 (default VGA) and instance 1 (small, active-high sync)
   int HA [2] = '{640, 20};
   int HF [2] = '{16, 4};
   int HS [2] = '{96, 6};
   int HB [2] = '{48, 5};
   int VA [2] = '{480, 12};
   int VF [2] = '{10, 3};
   int VS [2] = '{2, 2};
   int VB [2] = '{33, 4};
   bit POL[2] = '{1'b0, 1'b1};

   int mx [2];
   int my [2];
   bit mfresh [2];
   bit mls [2];
   bit mft [2];

   always #5 clk = ~clk;

   vga_sync_gen dut (
      .clk(clk), .reset(reset), .clk_en(clk_en),
      .CounterX(x0), .CounterY(y0), .hsync(hs0), .vsync(vs0),
      .inDisplayArea(da0), .line_start(ls0), .frame_tick(ft0)
   );

   vga_sync_gen #(
      .H_ACTIVE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
      .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
      .SYNC_POL(1'b1)
   ) dut_s (
      .clk(clk), .reset(reset), .clk_en(clk_en),
      .CounterX(x1), .CounterY(y1), .hsync(hs1), .vsync(vs1),
      .inDisplayArea(da1), .line_start(ls1), .frame_tick(ft1)
   );

   function automatic int htot(input int k);
      return HA[k] + HF[k] + HS[k] + HB[k];
   endfunction

   function automatic int vtot(input int k);
      return VA[k] + VF[k] + VS[k] + VB[k];
   endfunction

   // {x, y, hsync, vsync, display, line_start, frame_tick}
   function automatic logic [24:0] exp_vec(input int k);
      bit hs, vs, da;
      hs = (mx[k] >= HA[k] + HF[k] && mx[k] < HA[k] + HF[k] + HS[k]) ? POL[k] : !POL[k];
      vs = (my[k] >= VA[k] + VF[k] && my[k] < VA[k] + VF[k] + VS[k]) ? POL[k] : !POL[k];
      da = !mfresh[k] && mx[k] < HA[k] && my[k] < VA[k];
      return {10'(mx[k]), 10'(my[k]), hs, vs, da, mls[k], mft[k]};
   endfunction

   function automatic logic [24:0] act_vec(input int k);
      if (k == 0) return {x0, y0, hs0, vs0, da0, ls0, ft0};
      return {x1, y1, hs1, vs1, da1, ls1, ft1};
   endfunction

   task automatic step(input bit en, input bit rst);
      clk_en = en;
      reset  = rst;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mx[k] = 0; my[k] = 0; mfresh[k] = 1'b1; mls[k] = 1'b0; mft[k] = 1'b0;
         end else if (en) begin
            mx[k]     = (mx[k] + 1) % htot(k);
            mls[k]    = (mx[k] == 0);
            if (mls[k]) my[k] = (my[k] + 1) % vtot(k);
            mft[k]    = mls[k] && (my[k] == VA[k]);
            mfresh[k] = 1'b0;
         end else begin
            mls[k] = 1'b0;
            mft[k] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (act_vec(k) !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL reset inst%0d: got %h expected %h", k, act_vec(k), exp_vec(k));
         end
      end
   endtask

   task automatic test_line();
      int low_cnt, first_low, last_low, run_breaks;
      bit prev_low;
      low_cnt = 0; first_low = -1; last_low = -1; run_breaks = 0; prev_low = 1'b0;
      for (int i = 0; i < 800; i++) begin
         step(1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL line inst%0d cyc%0d: got %h expected %h", k, i, act_vec(k), exp_vec(k));
            end
         end
         if (hs0 === 1'b0) begin
            if (first_low < 0) first_low = int'(x0);
            else if (!prev_low) run_breaks++;
            last_low = int'(x0);
            low_cnt++;
         end
         prev_low = (hs0 === 1'b0);
      end
      n_checks++;
      if (low_cnt != 96 || first_low != 656 || last_low != 751 || run_breaks != 0) begin
         n_fail++;
         $display("FAIL hsync_window: got cnt=%0d first=%0d last=%0d breaks=%0d expected 96/656/751/0",
                  low_cnt, first_low, last_low, run_breaks);
      end
      n_checks++;
      if (x0 !== 10'd0 || y0 !== 10'd1) begin
         n_fail++;
         $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", x0, y0);
      end
   endtask

   task automatic test_frame();
      int vs_cnt, ft_cnt, ls_cnt, da_cnt, da_bad;
      step(1'b1, 1'b1);
      vs_cnt = 0; ft_cnt = 0; ls_cnt = 0; da_cnt = 0; da_bad = 0;
      for (int i = 0; i < 21 * 35; i++) begin
         step(1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL frame inst%0d cyc%0d: got %h expected %h", k, i, act_vec(k), exp_vec(k));
            end
         end
         if (vs1 === 1'b1) vs_cnt++;
         if (ls1 === 1'b1) ls_cnt++;
         if (da1 === 1'b1) begin
            da_cnt++;
            if (x1 >= 10'd20 || y1 >= 10'd12) da_bad++;
         end
         if (ft1 === 1'b1) begin
            ft_cnt++;
            n_checks++;
            if (x1 !== 10'd0 || y1 !== 10'd12) begin
               n_fail++;
               $display("FAIL frame_tick_pos: got (%0d,%0d) expected (0,12)", x1, y1);
            end
         end
      end
      n_checks++;
      if (vs_cnt != 70 || ft_cnt != 1 || ls_cnt != 21) begin
         n_fail++;
         $display("FAIL frame_counts: got vs=%0d ft=%0d ls=%0d expected 70/1/21", vs_cnt, ft_cnt, ls_cnt);
      end
      n_checks++;
      if (da_cnt != 240 || da_bad != 0) begin
         n_fail++;
         $display("FAIL display_count: got %0d (outside=%0d) expected 240 (0)", da_cnt, da_bad);
      end
   endtask

   task automatic test_clk_en_toggle();
      bit prev_ls, prev_ft;
      int wide;
      wide = 0; prev_ls = 1'b0; prev_ft = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step(i[0] == 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL toggle inst%0d cyc%0d: got %h expected %h", k, i, act_vec(k), exp_vec(k));
            end
         end
         if ((prev_ls && ls1 === 1'b1) || (prev_ft && ft1 === 1'b1)) wide++;
         prev_ls = (ls1 === 1'b1);
         prev_ft = (ft1 === 1'b1);
      end
      n_checks++;
      if (wide != 0) begin
         n_fail++;
         $display("FAIL pulse_width: got %0d wide pulses expected 0", wide);
      end
   endtask

   task automatic test_reset_mid();
      int pre;
      pre = 300 + int'($urandom_range(0, 200));
      for (int i = 0; i < pre; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (act_vec(k) !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL reset_mid inst%0d: got %h expected %h", k, act_vec(k), exp_vec(k));
         end
      end
      n_checks++;
      if (x0 !== 10'd0 || y0 !== 10'd0 || hs0 !== 1'b1 || vs0 !== 1'b1 || da0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_default: got x=%0d y=%0d hs=%b vs=%b da=%b expected 0 0 1 1 0",
                  x0, y0, hs0, vs0, da0);
      end
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL resume inst%0d cyc%0d: got %h expected %h", k, i, act_vec(k), exp_vec(k));
            end
         end
      end
   endtask

   task automatic test_random();
      bit en, rst;
      for (int i = 0; i < 3000; i++) begin
         en  = ($urandom_range(0, 99) < 70);
         rst = ($urandom_range(0, 999) == 0);
         step(en, rst);
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (act_vec(k) !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL random inst%0d cyc%0d: got %h expected %h", k, i, act_vec(k), exp_vec(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_clk_en_toggle();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
